// File: rtl/file_reg_bank_pkg.sv
// rtl/file_reg_bank_pkg.sv - file register map constants and default geometry
package file_reg_bank_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_GPR_BASE = 8;
  localparam int DEF_GPR_TOP  = 31;

  typedef enum logic [4:0] {
    ADDR_INDF   = 5'd0,
    ADDR_TMR0   = 5'd1,
    ADDR_PCL    = 5'd2,
    ADDR_STATUS = 5'd3,
    ADDR_FSR    = 5'd4,
    ADDR_PORTA  = 5'd5,
    ADDR_PORTB  = 5'd6,
    ADDR_PORTC  = 5'd7
  } file_addr_e;

  function automatic logic in_gpr_range(input int addr, input int lo, input int hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/file_addr_resolve.sv
// rtl/file_addr_resolve.sv - INDF/FSR address mux, null-indirect detect, SFR one-hot decode
module file_addr_resolve
  import file_reg_bank_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int GPR_BASE = DEF_GPR_BASE
) (
  input  logic [ADDR_W-1:0]   f_addr,
  input  logic [ADDR_W-1:0]   fsr_ptr,
  input  logic                rd_en,
  input  logic                wr_en,
  output logic [ADDR_W-1:0]   eff_addr,
  output logic                null_ind,
  output logic [GPR_BASE-1:0] sfr_out_en,
  output logic [GPR_BASE-1:0] sfr_write_en
);

  logic is_indf;

  assign is_indf  = (f_addr == ADDR_W'(ADDR_INDF));
  assign eff_addr = is_indf ? fsr_ptr : f_addr;
  assign null_ind = is_indf && (fsr_ptr == '0);

  // A null indirect resolves to address 0, so it must not strobe the INDF slot either
  always_comb begin
    sfr_out_en   = '0;
    sfr_write_en = '0;
    for (int i = 0; i < GPR_BASE; i++) begin
      if (!null_ind && (int'(eff_addr) == i)) begin
        sfr_out_en[i]   = rd_en;
        sfr_write_en[i] = wr_en;
      end
    end
  end

endmodule

// File: rtl/file_reg_bank.sv
// rtl/file_reg_bank.sv - GPR array with indirect addressing and SFR strobe decode
module file_reg_bank
  import file_reg_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int GPR_BASE = DEF_GPR_BASE,
  parameter int GPR_TOP  = DEF_GPR_TOP
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   f_addr,
  input  logic [ADDR_W-1:0]   fsr_ptr,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic [ADDR_W-1:0]   eff_addr,
  output logic [GPR_BASE-1:0] sfr_out_en,
  output logic [GPR_BASE-1:0] sfr_write_en,
  output logic                indirect_null
);

  localparam int NUM_GPR = GPR_TOP - GPR_BASE + 1;
  localparam int IDX_W   = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;

  logic [DATA_W-1:0] gpr [NUM_GPR];
  logic              null_ind;
  logic              gpr_hit;
  logic [IDX_W-1:0]  gpr_idx;
  logic [DATA_W-1:0] rd_val;
  logic              bus_drive;

  file_addr_resolve #(
    .ADDR_W   (ADDR_W),
    .GPR_BASE (GPR_BASE)
  ) u_resolve (
    .f_addr       (f_addr),
    .fsr_ptr      (fsr_ptr),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .eff_addr     (eff_addr),
    .null_ind     (null_ind),
    .sfr_out_en   (sfr_out_en),
    .sfr_write_en (sfr_write_en)
  );

  assign gpr_hit = in_gpr_range(int'(eff_addr), GPR_BASE, GPR_TOP);
  assign gpr_idx = IDX_W'(int'(eff_addr) - GPR_BASE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
      indirect_null <= 1'b0;
    end else begin
      if (wr_en && gpr_hit) gpr[gpr_idx] <= data_in;
      indirect_null <= null_ind && (rd_en || wr_en);
    end
  end

  // Null indirect reads return zero; SFR and out-of-range reads leave the bus to others
  always_comb begin
    rd_val = '0;
    if (gpr_hit && !null_ind) rd_val = gpr[gpr_idx];
  end

  assign bus_drive = rd_en && (gpr_hit || null_ind);
  assign data_out  = bus_drive ? rd_val : {DATA_W{1'bz}};

endmodule

// File: tb/tb_file_reg_bank.sv
// tb/tb_file_reg_bank.sv - scoreboard bench for file_reg_bank
module tb_file_reg_bank;

  localparam logic [7:0] ZB = 8'hFF;

  typedef struct {
    string      name;
    logic [7:0] dout;
    logic [4:0] eff;
    logic [7:0] soe;
    logic [7:0] swe;
    logic       inull;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] f_addr;
  logic [4:0] fsr_ptr;
  logic       rd_en;
  logic       wr_en;
  logic [7:0] data_in;
  wire  [7:0] data_out;
  logic [4:0] eff_addr;
  logic [7:0] sfr_out_en;
  logic [7:0] sfr_write_en;
  logic       indirect_null;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Undriven bus floats high so a released bus reads as ZB
  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup (data_out[g]);
  end

  file_reg_bank dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .f_addr        (f_addr),
    .fsr_ptr       (fsr_ptr),
    .rd_en         (rd_en),
    .wr_en         (wr_en),
    .data_in       (data_in),
    .data_out      (data_out),
    .eff_addr      (eff_addr),
    .sfr_out_en    (sfr_out_en),
    .sfr_write_en  (sfr_write_en),
    .indirect_null (indirect_null)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".dout"}, data_out, e.dout);
      check({e.name, ".eff"}, {3'b000, eff_addr}, {3'b000, e.eff});
      check({e.name, ".soe"}, sfr_out_en, e.soe);
      check({e.name, ".swe"}, sfr_write_en, e.swe);
      check({e.name, ".inull"}, {7'b0, indirect_null}, {7'b0, e.inull});
    end
  end

  task automatic drive(input logic [4:0] f, input logic [4:0] p, input logic rd,
                       input logic wr, input logic [7:0] din);
    f_addr  = f;
    fsr_ptr = p;
    rd_en   = rd;
    wr_en   = wr;
    data_in = din;
  endtask

  task automatic push_exp(input string name, input logic [7:0] dout, input logic [4:0] eff,
                          input logic [7:0] soe, input logic [7:0] swe, input logic inull);
    exp_t e;
    e.name  = name;
    e.dout  = dout;
    e.eff   = eff;
    e.soe   = soe;
    e.swe   = swe;
    e.inull = inull;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input string name, input logic [4:0] f, input logic [4:0] p,
                      input logic rd, input logic wr, input logic [7:0] din,
                      input logic [7:0] dout, input logic [4:0] eff,
                      input logic [7:0] soe, input logic [7:0] swe, input logic inull);
    drive(f, p, rd, wr, din);
    push_exp(name, dout, eff, soe, swe, inull);
    next_cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    drive(5'h08, 5'h00, 1'b0, 1'b0, 8'h00);
    next_cycle();

    //    name         f      fsr    rd wr  din     dout   eff    soe    swe    inull
    step("t1_rst",    5'h08, 5'h00, 1, 0, 8'h00,  8'h00, 5'h08, 8'h00, 8'h00, 0);
    reset_n = 1'b1;
    step("t1_rd",     5'h08, 5'h00, 1, 0, 8'h00,  8'h00, 5'h08, 8'h00, 8'h00, 0);
    step("t2_wr",     5'h1F, 5'h00, 0, 1, 8'hA5,  ZB,    5'h1F, 8'h00, 8'h00, 0);
    step("t2_rd",     5'h1F, 5'h00, 1, 0, 8'h00,  8'hA5, 5'h1F, 8'h00, 8'h00, 0);
    step("t2_z",      5'h1F, 5'h00, 0, 0, 8'h00,  ZB,    5'h1F, 8'h00, 8'h00, 0);
    step("t3_wr",     5'h00, 5'h0C, 0, 1, 8'h3C,  ZB,    5'h0C, 8'h00, 8'h00, 0);
    step("t3_rd",     5'h0C, 5'h0C, 1, 0, 8'h00,  8'h3C, 5'h0C, 8'h00, 8'h00, 0);
    step("t4_rd",     5'h04, 5'h0C, 1, 0, 8'h00,  ZB,    5'h04, 8'h10, 8'h00, 0);
    step("t4_wr",     5'h04, 5'h0C, 0, 1, 8'hEE,  ZB,    5'h04, 8'h00, 8'h10, 0);
    step("t4_chk1f",  5'h1F, 5'h0C, 1, 0, 8'h00,  8'hA5, 5'h1F, 8'h00, 8'h00, 0);
    step("t4_chk0c",  5'h0C, 5'h0C, 1, 0, 8'h00,  8'h3C, 5'h0C, 8'h00, 8'h00, 0);
    step("t5_wr",     5'h00, 5'h00, 0, 1, 8'hFF,  ZB,    5'h00, 8'h00, 8'h00, 0);
    step("t5_rd",     5'h00, 5'h00, 1, 0, 8'h00,  8'h00, 5'h00, 8'h00, 8'h00, 1);
    step("t5_chk0c",  5'h0C, 5'h00, 1, 0, 8'h00,  8'h3C, 5'h0C, 8'h00, 8'h00, 1);
    step("t5_chk1f",  5'h1F, 5'h00, 1, 0, 8'h00,  8'hA5, 5'h1F, 8'h00, 8'h00, 0);
    step("t5_rdwr",   5'h00, 5'h00, 1, 1, 8'hFF,  8'h00, 5'h00, 8'h00, 8'h00, 0);
    step("t5_idle",   5'h00, 5'h00, 0, 0, 8'h00,  ZB,    5'h00, 8'h00, 8'h00, 1);
    step("t5_clr",    5'h00, 5'h00, 0, 0, 8'h00,  ZB,    5'h00, 8'h00, 8'h00, 0);
    step("sfr7",      5'h07, 5'h00, 1, 1, 8'h12,  ZB,    5'h07, 8'h80, 8'h80, 0);
    step("base_rw",   5'h08, 5'h00, 1, 1, 8'h5A,  8'h00, 5'h08, 8'h00, 8'h00, 0);
    step("base_rd",   5'h08, 5'h00, 1, 0, 8'h00,  8'h5A, 5'h08, 8'h00, 8'h00, 0);
    step("sfr1_wr",   5'h01, 5'h00, 0, 1, 8'h33,  ZB,    5'h01, 8'h00, 8'h02, 0);
    step("t6_wr",     5'h10, 5'h00, 0, 1, 8'h55,  ZB,    5'h10, 8'h00, 8'h00, 0);
    step("t6_rd",     5'h10, 5'h00, 1, 0, 8'h00,  8'h55, 5'h10, 8'h00, 8'h00, 0);
    step("t6_null",   5'h00, 5'h00, 1, 0, 8'h00,  8'h00, 5'h00, 8'h00, 8'h00, 0);

    // Reset lands mid-cycle with a write pending; the write must be dropped
    drive(5'h10, 5'h00, 1'b1, 1'b1, 8'h77);
    #1 reset_n = 1'b0;
    push_exp("t6_inrst", 8'h00, 5'h10, 8'h00, 8'h00, 1'b0);
    next_cycle();
    reset_n = 1'b1;
    step("t6_after",  5'h10, 5'h00, 1, 0, 8'h00,  8'h00, 5'h10, 8'h00, 8'h00, 0);
    step("t6_chk1f",  5'h1F, 5'h00, 1, 0, 8'h00,  8'h00, 5'h1F, 8'h00, 8'h00, 0);
    step("t6_chk08",  5'h08, 5'h00, 1, 0, 8'h00,  8'h00, 5'h08, 8'h00, 8'h00, 0);

    begin : drain
      int budget;
      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clock);
        budget--;
      end
      if (exp_q.size() > 0) begin
        total++;
        bad++;
        $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/file_reg_bank.md
Name: file_reg_bank

Overview:
- General-purpose file register bank with indirect-address resolution, sitting directly downstream of the FSR register's 5-bit pointer output.
- Resolves the instruction's 5-bit file field: INDF (address 0) → use FSR pointer, else direct.
- Stores GPRs 0x08–0x1F internally; for 0x00–0x07, decodes one-hot read/write strobes to the SFR registers (FSR, STATUS, PORTs…) on the shared tri-state data bus.

Parameters:
- DATA_W, 8, data bus width.
- ADDR_W, 5, file address width.
- GPR_BASE, 8, first GPR address; addresses below are SFR space.
- GPR_TOP, 31, last GPR address (inclusive).

Ports:
- clock  in  1  rising-edge system clock.
- reset_n  in  1  asynchronous active-low reset.
- f_addr  in  ADDR_W  file field from decoded instruction.
- fsr_ptr  in  ADDR_W  pointer from FSR register (value[4:0]).
- rd_en  in  1  drive bus with resolved register this cycle.
- wr_en  in  1  write data_in into resolved register on the next rising edge.
- data_in  in  DATA_W  write data from ALU/W path.
- data_out  out  DATA_W  tri-state bus; Z unless a GPR or INDF-null read is active.
- eff_addr  out  ADDR_W  resolved effective address (combinational).
- sfr_out_en  out  GPR_BASE  one-hot SFR output enable (index = eff_addr).
- sfr_write_en  out  GPR_BASE  one-hot SFR write enable.
- indirect_null  out  1  registered flag: last access was INDF through FSR=0.

Behaviour:
- Clock/reset fixed: single clock `clock`; reset `reset_n` is asynchronous, active-low.
- Address resolution (combinational):
  - eff_addr = (f_addr == 0) ? fsr_ptr : f_addr.
  - Null indirect: f_addr == 0 and fsr_ptr == 0.
- GPR array, GPR_TOP-GPR_BASE+1 entries (24 × 8 by default):
  - Write on rising clock when wr_en=1 and GPR_BASE ≤ eff_addr ≤ GPR_TOP.
  - data_in and eff_addr are sampled at that edge; no write-bypass needed.
- Read (combinational):
  - rd_en=1 and eff_addr is a GPR → data_out = array[eff_addr-GPR_BASE].
  - Null indirect with rd_en=1 → data_out = 8'h00 (driven).
  - Otherwise data_out = Z.
- SFR decode, eff_addr < GPR_BASE and not null indirect:
  - sfr_out_en[eff_addr] = rd_en.
  - sfr_write_en[eff_addr] = wr_en.
  - All other bits 0.
  - This block never drives the bus for SFRs; the selected SFR drives it.
- Null indirect:
  - All sfr_* enables 0.
  - Write is a no-op; no GPR or SFR changes.
  - indirect_null <= 1 at the next edge if rd_en|wr_en, else <= 0.
- Simultaneous rd_en & wr_en, same address:
  - data_out shows the old value during the cycle.
  - New value is visible from the cycle after the edge.
- Reset, asserted at any time including mid-write:
  - Immediately clears all GPRs to 8'h00 and indirect_null to 0.
  - A write coinciding with reset is dropped.
  - Combinational outputs follow inputs during reset, but the GPR read value is 0.
- Bus contention rule: at most one of {this block, any SFR} drives data_out in any cycle; guaranteed by the decode above.
- Out-of-range address (eff_addr > GPR_TOP, only possible if parameters shrink the range):
  - Reads give Z.
  - Writes are ignored.

Decomposition:
- Shared package holds:
  - File-map constants: ADDR_INDF=0, ADDR_TMR0=1, ADDR_PCL=2, ADDR_STATUS=3, ADDR_FSR=4, ADDR_PORTA..PORTC=5..7.
  - GPR_BASE/GPR_TOP and the DATA_W/ADDR_W defaults.
- One natural sub-module: file_addr_resolve, covering INDF/FSR mux, null-indirect detect, and SFR one-hot decode (pure combinational).
- The top holds the array, read mux, tri-state driver and indirect_null flop.

Test Plan:
1. Reset then read: reset_n=0, release; f_addr=0x08, rd_en=1 → data_out=0x00, indirect_null=0, all sfr_* = 0.
2. Direct write/read: wr_en=1, f_addr=0x1F, data_in=0xA5, edge; next cycle rd_en=1 → data_out=0xA5; rd_en=0 → Z.
3. Indirect GPR: fsr_ptr=0x0C, f_addr=0, wr 0x3C; then f_addr=0x0C, rd → 0x3C, eff_addr=0x0C.
4. SFR decode: f_addr=0x04, rd_en=1 → sfr_out_en=8'b0001_0000, data_out=Z; wr_en=1 → sfr_write_en=8'b0001_0000, no GPR change.
5. Null indirect: fsr_ptr=0, f_addr=0, wr 0xFF then rd → data_out=0x00, sfr_* all 0, indirect_null=1 after edge, GPR contents unchanged.
6. Reset mid-op: write 0x55 to 0x10; assert reset_n=0 between edges with wr_en=1, data_in=0x77; release → read 0x10 = 0x00.
